// File: rtl/mem_in_reader.sv
// Sequential byte reader for the input-activation memory bank. Issues one-cycle-latency
// reads from a base address and streams the bytes out through a 2-entry skid FIFO.
module mem_in_reader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [LEN_W-1:0] ONE_LEN = 1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  issued_reg;
  logic [LEN_W-1:0]  popped_reg;
  logic              inflight_reg;
  logic              done_reg, done_next;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [1:0]        count_reg;

  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic              last_beat;
  logic [2:0]        credit_use;
  logic [LEN_W-1:0]  issued_plus;

  // Reads in flight plus buffered bytes, net of this cycle's pop, bound the FIFO depth.
  assign pop        = (count_reg != 2'd0) && out_ready;
  assign push       = inflight_reg;
  assign credit_use = {2'b00, inflight_reg} + {1'b0, count_reg} - {2'b00, pop};
  assign issue      = (state_reg == RUN) && (issued_reg < len_reg) && (credit_use < 3'd2);
  assign issued_plus = issued_reg + ONE_LEN;
  assign accept     = (state_reg == IDLE) && start;
  assign last_beat  = (popped_reg == (len_reg - ONE_LEN));

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign mem_cen   = ~issue;
  assign mem_wen   = 1'b1;
  assign mem_a     = issue ? (base_reg + ADDR_W'(issued_reg)) : addr_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = fifo_mem[rd_ptr_reg];
  assign out_last  = out_valid && last_beat;

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len != '0) state_next = RUN;
          else           done_next  = 1'b1;
        end
      end
      RUN: begin
        if (issue && (issued_plus == len_reg)) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = DRAIN;
      end
      default: state_next = IDLE;
    endcase
    // The final handshake ends the transfer; nothing can still be in flight by then.
    if ((state_reg != IDLE) && pop && out_last) begin
      state_next = IDLE;
      done_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      done_reg     <= 1'b0;
      base_reg     <= '0;
      len_reg      <= '0;
      issued_reg   <= '0;
      popped_reg   <= '0;
      addr_reg     <= '0;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      done_reg     <= done_next;
      addr_reg     <= mem_a;
      inflight_reg <= issue;
      if (accept) begin
        base_reg   <= base_addr;
        len_reg    <= len;
        issued_reg <= '0;
        popped_reg <= '0;
      end else begin
        if (issue) issued_reg <= issued_plus;
        if (pop)   popped_reg <= popped_reg + ONE_LEN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_reg] <= mem_q;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_in_reader.sv
// Directed bench for mem_in_reader: memory model returns A[i] = i & 0xFF one cycle after CEN.
module tb_mem_in_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] len;
  logic        busy, done, mem_cen, mem_wen;
  logic [15:0] mem_a;
  logic [7:0]  mem_q;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_in_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a),
    .mem_q(mem_q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  always @(posedge clk) if (!mem_cen) mem_q <= mem_a[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "/busy"}, busy, 0);
    chk({tag, "/done"}, done, 0);
    chk({tag, "/mem_cen"}, mem_cen, 1);
    chk({tag, "/mem_wen"}, mem_wen, 1);
    chk({tag, "/mem_a"}, mem_a, 0);
    chk({tag, "/out_valid"}, out_valid, 0);
    chk({tag, "/out_last"}, out_last, 0);
    chk({tag, "/out_data"}, out_data, 0);
  endtask

  // One transfer: start, then per cycle record issued addresses, popped bytes and done.
  task automatic run_xfer(input string name, input logic [15:0] base, input logic [15:0] n,
                          input bit toggle, input bit restart_mid, input int abort_pops);
    logic [15:0] addrs[$];
    logic [7:0]  datas[$];
    logic [3:0]  pat = 4'b1001;
    int          iss = 0, pops = 0, done_cnt = 0;
    int          first_valid = -1, done_idx = -1;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = '0;
    int          pop_now;
    @(posedge clk); #1;
    start = 1; base_addr = base; len = n; out_ready = 1;
    @(posedge clk); #1;
    start = 0; base_addr = 16'h5555; len = 16'h7777;
    chk({name, "/busy_after_start"}, busy, (n != 0));
    for (int idx = 1; idx <= 300; idx++) begin
      out_ready = toggle ? pat[(idx - 1) % 4] : 1'b1;
      if (restart_mid && idx == 2) begin
        start = 1; base_addr = 16'h2000; len = 16'd3;
      end else begin
        start = 0;
      end
      #1;
      if (prev_stall) begin
        chk({name, "/stall_valid"}, out_valid, 1);
        chk({name, "/stall_data"}, out_data, prev_data);
      end
      pop_now = (out_valid && out_ready) ? 1 : 0;
      if (!mem_cen) begin
        chk({name, "/credit"}, ((iss - pops - pop_now) < 2), 1);
        addrs.push_back(mem_a);
        iss++;
      end
      if (out_valid && first_valid < 0) first_valid = idx;
      if (pop_now != 0) begin
        datas.push_back(out_data);
        chk({name, "/out_last"}, out_last, (pops == int'(n) - 1));
        pops++;
      end
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = idx;
        chk({name, "/busy_at_done"}, busy, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (abort_pops != 0 && pops == abort_pops) return;
      if (done_idx >= 0 && idx >= done_idx + 3) break;
      @(posedge clk); #1;
    end
    start = 0;
    $display("xfer %s base=%04h len=%0d issued=%0d popped=%0d done_idx=%0d",
             name, base, n, iss, pops, done_idx);
    chk({name, "/done_count"}, done_cnt, 1);
    chk({name, "/issued"}, iss, n);
    chk({name, "/popped"}, pops, n);
    if (n != 0) chk({name, "/first_valid_cycle"}, first_valid, 3);
    else        chk({name, "/no_valid"}, first_valid, 32'hFFFF_FFFF);
    if (!toggle) chk({name, "/done_cycle"}, done_idx, (n == 0) ? 1 : int'(n) + 3);
    for (int i = 0; i < addrs.size() && i < int'(n); i++)
      chk({name, "/addr"}, addrs[i], (int'(base) + i) & 16'hFFFF);
    for (int i = 0; i < datas.size() && i < int'(n); i++)
      chk({name, "/data"}, datas[i], (int'(base) + i) & 8'hFF);
  endtask

  initial begin
    rst_n = 0; start = 0; base_addr = 0; len = 0; out_ready = 0;
    #2;
    chk_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    run_xfer("basic", 16'h0100, 16'd4, 0, 0, 0);
    run_xfer("backpressure", 16'h0100, 16'd4, 1, 0, 0);
    run_xfer("backpressure8", 16'h0040, 16'd8, 1, 0, 0);
    run_xfer("len0", 16'h0100, 16'd0, 0, 0, 0);
    run_xfer("wrap", 16'hFFFE, 16'd4, 0, 0, 0);
    run_xfer("ignore_start", 16'h0200, 16'd5, 0, 1, 0);

    // Abort an 8-byte transfer after two bytes are popped.
    run_xfer("abort", 16'h0300, 16'd8, 0, 0, 2);
    rst_n = 0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_reset/done", done, 0);
      chk("post_reset/out_valid", out_valid, 0);
      chk("post_reset/mem_cen", mem_cen, 1);
    end
    run_xfer("after_reset", 16'h0010, 16'd2, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
